// File: rtl/seq_detector_param.sv
`default_nettype none
// ============================================================================
//  Module      : seq_detector_param
//  Description : Parametrised Moore serial pattern detector. One serial bit is
//                accepted per clock while valid is high; the last N accepted
//                bits are compared against a run-time reloadable pattern.
//                Overlapping or non-overlapping detection, saturating match
//                counter.
//  Ports       : clk          - rising-edge clock
//                reset        - synchronous active-high reset
//                valid        - A is accepted on this edge when high
//                A            - serial data bit (first bit = pattern MSB)
//                load_en      - load load_pattern, discard current window
//                load_pattern - new pattern, MSB first
//                unlock       - registered match flag (Moore)
//                match_cnt    - matches since reset, saturating
//                fill         - bits accepted in current window, 0..N
//  Revision    : 1.0 - initial release
// ============================================================================
module seq_detector_param #(
   parameter int               N       = 5,
   parameter logic [N-1:0]     PATTERN = 5'b01001,
   parameter int               OVERLAP = 1,
   parameter int               CNT_W   = 8
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic                        valid,
   input  logic                        A,
   input  logic                        load_en,
   input  logic [N-1:0]                load_pattern,
   output logic                        unlock,
   output logic [CNT_W-1:0]            match_cnt,
   output logic [$clog2(N+1)-1:0]      fill
);

   localparam int                FILL_W   = $clog2(N+1);
   localparam logic [FILL_W-1:0] FILL_N   = FILL_W'(N);
   localparam logic [FILL_W-1:0] FILL_ONE = FILL_W'(1);
   localparam logic              NO_OVL   = (OVERLAP == 0);

   logic [N-1:0]      hist_q,    hist_d;
   logic [FILL_W-1:0] fill_q,    fill_d;
   logic              unlock_q,  unlock_d;
   logic [CNT_W-1:0]  cnt_q,     cnt_d;
   logic [N-1:0]      pattern_q, pattern_d;
   logic              restart;
   logic              hit;

   // State register
   always_ff @(posedge clk) begin
      if (reset) begin
         hist_q    <= '0;
         fill_q    <= '0;
         unlock_q  <= 1'b0;
         cnt_q     <= '0;
         pattern_q <= PATTERN;
      end else begin
         hist_q    <= hist_d;
         fill_q    <= fill_d;
         unlock_q  <= unlock_d;
         cnt_q     <= cnt_d;
         pattern_q <= pattern_d;
      end
   end

   // Next-state logic
   always_comb begin
      hist_d    = hist_q;
      fill_d    = fill_q;
      unlock_d  = unlock_q;
      cnt_d     = cnt_q;
      pattern_d = pattern_q;
      hit       = 1'b0;
      // In non-overlapping mode the bit after a match opens a fresh window,
      // so the matched bits cannot contribute to the next match.
      restart   = unlock_q & NO_OVL;

      if (load_en) begin
         pattern_d = load_pattern;
         hist_d    = '0;
         fill_d    = '0;
         unlock_d  = 1'b0;
      end else if (valid) begin
         hist_d = {hist_q[N-2:0], A};
         if (restart) begin
            fill_d = FILL_ONE;
         end else if (fill_q == FILL_N) begin
            fill_d = FILL_N;
         end else begin
            fill_d = fill_q + 1'b1;
         end
         // A full window is required: stale history left over from before a
         // reset/load/restart must never match on its own.
         hit      = (fill_d == FILL_N) && (hist_d == pattern_q);
         unlock_d = hit;
         if (hit && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + 1'b1;
         end
      end
   end

   // Output logic
   always_comb begin
      unlock    = unlock_q;
      match_cnt = cnt_q;
      fill      = fill_q;
   end

endmodule
`default_nettype wire

// File: tb/tb_seq_detector_param.sv
`default_nettype none
// ============================================================================
//  Module      : tb_seq_detector_param
//  Description : Self-checking bench for seq_detector_param. Three instances
//                (overlapping N=5, non-overlapping N=5, overlapping N=3 with a
//                2-bit counter) share one stimulus stream. Expected outputs
//                come from a window-queue reference model and are checked by
//                an independent monitor process.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_seq_detector_param;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       reset, valid, A, load_en;
   logic [4:0] lp5;
   logic [2:0] lp3;

   logic       unl0, unl1, unl2;
   logic [7:0] cnt0, cnt1;
   logic [1:0] cnt2;
   logic [2:0] fill0, fill1;
   logic [1:0] fill2;

   seq_detector_param #(.N(5), .PATTERN(5'b01001), .OVERLAP(1), .CNT_W(8)) u0 (
      .clk(clk), .reset(reset), .valid(valid), .A(A), .load_en(load_en),
      .load_pattern(lp5), .unlock(unl0), .match_cnt(cnt0), .fill(fill0));

   seq_detector_param #(.N(5), .PATTERN(5'b01001), .OVERLAP(0), .CNT_W(8)) u1 (
      .clk(clk), .reset(reset), .valid(valid), .A(A), .load_en(load_en),
      .load_pattern(lp5), .unlock(unl1), .match_cnt(cnt1), .fill(fill1));

   seq_detector_param #(.N(3), .PATTERN(3'b010), .OVERLAP(1), .CNT_W(2)) u2 (
      .clk(clk), .reset(reset), .valid(valid), .A(A), .load_en(load_en),
      .load_pattern(lp3), .unlock(unl2), .match_cnt(cnt2), .fill(fill2));

   // Reference model: per instance, the list of bits in the current window.
   int NN   [3] = '{5, 5, 3};
   int OVL  [3] = '{1, 0, 1};
   int CMAX [3] = '{255, 255, 3};
   int DEFP [3] = '{9, 9, 2};
   int win  [3][$];
   int pat  [3];
   int munl [3];
   int mcnt [3];

   // Expected values: 9 ints per cycle (unlock, count, fill for each instance).
   int exp_q[$];
   int n_cmp = 0;
   int n_bad = 0;

   task automatic model_step(input int k, input int r, input int v, input int a,
                             input int le, input int lp);
      int val;
      if (r != 0) begin
         win[k].delete();
         munl[k] = 0;
         mcnt[k] = 0;
         pat[k]  = DEFP[k];
      end else if (le != 0) begin
         win[k].delete();
         munl[k] = 0;
         pat[k]  = lp;
      end else if (v != 0) begin
         if (munl[k] != 0 && OVL[k] == 0) win[k].delete();
         win[k].push_back(a);
         if (win[k].size() > NN[k]) void'(win[k].pop_front());
         val = 0;
         for (int i = 0; i < win[k].size(); i++) val = val * 2 + win[k][i];
         munl[k] = (win[k].size() == NN[k] && val == pat[k]) ? 1 : 0;
         if (munl[k] != 0 && mcnt[k] < CMAX[k]) mcnt[k]++;
      end
   endtask

   task automatic step(input logic r, input logic v, input logic a, input logic le,
                       input logic [4:0] p5, input logic [2:0] p3);
      @(negedge clk);
      reset = r; valid = v; A = a; load_en = le; lp5 = p5; lp3 = p3;
      for (int k = 0; k < 3; k++) begin
         model_step(k, int'(r), int'(v), int'(a), int'(le), (k == 2) ? int'(p3) : int'(p5));
         exp_q.push_back(munl[k]);
         exp_q.push_back(mcnt[k]);
         exp_q.push_back(win[k].size());
      end
   endtask

   task automatic send_bits(input logic [31:0] bits, input int len);
      for (int i = len - 1; i >= 0; i--) step(1'b0, 1'b1, bits[i], 1'b0, 5'b01001, 3'b010);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 1'b0, 5'b01001, 3'b010);
   endtask

   task automatic do_reset();
      step(1'b1, 1'b0, 1'b0, 1'b0, 5'b01001, 3'b010);
   endtask

   task automatic chk(input string name, input logic [31:0] act, input int expv);
      n_cmp++;
      if (act !== 32'(expv)) begin
         n_bad++;
         $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, expv);
      end
   endtask

   // Monitor: one set of results is due every cycle after the active edge.
   initial begin
      logic [31:0] act [3][3];
      forever begin
         @(posedge clk);
         #1;
         act[0][0] = 32'(unl0); act[0][1] = 32'(cnt0); act[0][2] = 32'(fill0);
         act[1][0] = 32'(unl1); act[1][1] = 32'(cnt1); act[1][2] = 32'(fill1);
         act[2][0] = 32'(unl2); act[2][1] = 32'(cnt2); act[2][2] = 32'(fill2);
         if (exp_q.size() >= 9) begin
            for (int k = 0; k < 3; k++) begin
               chk($sformatf("u%0d_unlock", k), act[k][0], exp_q.pop_front());
               chk($sformatf("u%0d_match_cnt", k), act[k][1], exp_q.pop_front());
               chk($sformatf("u%0d_fill", k), act[k][2], exp_q.pop_front());
            end
         end
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached, compared %0d", n_cmp);
      $fatal(1, "watchdog");
   end

   initial begin
      logic r, v, a, le;
      logic [4:0] p5;
      logic [2:0] p3;
      reset = 1'b1; valid = 1'b0; A = 1'b0; load_en = 1'b0; lp5 = 5'b01001; lp3 = 3'b010;

      // Reset state, then the reference stream (hits after bits 6, 9, 15).
      do_reset();
      send_bits(32'b1010010011010011, 16);

      // Partial window, idle cycles, completing bit; unlock held while idle.
      do_reset();
      send_bits(32'b0100, 4);
      idle(3);
      send_bits(32'b1, 1);
      idle(3);

      // Pattern reload keeps the count from the previous run.
      do_reset();
      send_bits(32'b1010010011010011, 16);
      step(1'b0, 1'b1, 1'b1, 1'b1, 5'b11100, 3'b010);
      send_bits(32'b0111001110011, 13);

      // Mid-stream reset discards the partial window.
      do_reset();
      send_bits(32'b0100, 4);
      do_reset();
      send_bits(32'b1, 1);

      // Overlapping 010 hits saturate the 2-bit counter.
      do_reset();
      send_bits(32'b01010101010, 11);
      idle(2);

      // Randomized traffic with occasional reset and reload.
      do_reset();
      for (int i = 0; i < 800; i++) begin
         r  = ($urandom_range(99) == 0);
         le = ($urandom_range(39) == 0);
         v  = ($urandom_range(3) != 0);
         a  = 1'($urandom_range(1));
         p5 = ($urandom_range(1) == 0) ? 5'b01001 : 5'($urandom_range(31));
         p3 = 3'($urandom_range(7));
         step(r, v, a, le, p5, p3);
      end

      repeat (3) @(negedge clk);
      chk("scoreboard_drained", 32'(exp_q.size()), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
`default_nettype wire
